// File: rtl/tt_um_press_counter.sv
`default_nettype none
// ============================================================================
// tt_um_press_counter: synchronised, debounced UP/DOWN/CLEAR press counter.
// Optional status outputs on uio when PRESS_STATUS_EN is defined.  Rev 1.0
// ============================================================================
module tt_um_press_counter #(
  parameter int DEB_CYCLES = 25000,
  parameter int DEB_W      = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);

  localparam int               NUM_BTN  = 3;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [NUM_BTN-1:0] deb;
  logic [NUM_BTN-1:0] deb_prev_q;
  logic [NUM_BTN-1:0] press;
  logic [7:0]         count_q;
  logic [7:0]         count_d;
  logic               unused_inputs;

  assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:3]};

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    logic             sync1_q;
    logic             raw_q;
    logic             deb_q;
    logic             deb_d;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;

    // Any sample agreeing with the current state restarts the stability window.
    always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (raw_q != deb_q) begin
        if (cnt_q == DEB_LAST) begin
          deb_d = raw_q;
        end else begin
          cnt_d = cnt_q + DEB_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= 1'b0;
        raw_q   <= 1'b0;
        deb_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= ui_in[b];
        raw_q   <= sync1_q;
        deb_q   <= deb_d;
        cnt_q   <= cnt_d;
      end
    end

    assign deb[b] = deb_q;
  end

  assign press = deb & ~deb_prev_q;

  always_comb begin
    count_d = count_q;
    if (press[2]) begin
      count_d = 8'h00;
    end else if (press[0] && !press[1]) begin
      count_d = count_q + 8'd1;
    end else if (press[1] && !press[0]) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_prev_q <= '0;
      count_q    <= 8'h00;
    end else begin
      deb_prev_q <= deb;
      count_q    <= count_d;
    end
  end

  assign uo_out = count_q;

`ifdef PRESS_STATUS_EN
  logic       wrap_flag_q;
  logic       wrap_flag_d;
  logic [7:0] oe_q;

  always_comb begin
    wrap_flag_d = wrap_flag_q;
    if (press[2]) begin
      wrap_flag_d = 1'b0;
    end else if (press[0] && !press[1] && (count_q == 8'hFF)) begin
      wrap_flag_d = 1'b1;
    end else if (press[1] && !press[0] && (count_q == 8'h00)) begin
      wrap_flag_d = 1'b1;
    end
  end

  // Enables are held low in reset so the pads stay inputs until the first clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_flag_q <= 1'b0;
      oe_q        <= 8'h00;
    end else begin
      wrap_flag_q <= wrap_flag_d;
      oe_q        <= 8'h0F;
    end
  end

  assign uio_out = {4'h0, wrap_flag_q, deb};
  assign uio_oe  = oe_q;
`else
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tt_um_press_counter.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for tt_um_press_counter with DEB_CYCLES=4, checked against a
// sliding-window behavioural model of debounce and press counting.
module tb_tt_um_press_counter;

  localparam int DEB = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic       ena = 1'b1;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tt_um_press_counter #(
    .DEB_CYCLES(DEB),
    .DEB_W     (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena)
  );

  // Model: hist[n] is ui_in[2:0] sampled n+1 edges ago. A button's debounced
  // state flips once the last DEB synchronised samples all disagree with it.
  logic [2:0] hist [0:7];
  logic [2:0] m_deb;
  logic [2:0] m_press;
  logic [7:0] m_count;
  logic       m_flag;
  logic [7:0] m_oe;

  always @(posedge clk or negedge rst_n) begin : model
    logic [7:0] c;
    logic       f;
    logic [2:0] d;
    logic [2:0] p;
    logic       differs;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) hist[i] <= 3'b000;
      m_deb   <= 3'b000;
      m_press <= 3'b000;
      m_count <= 8'h00;
      m_flag  <= 1'b0;
      m_oe    <= 8'h00;
    end else begin
      c = m_count;
      f = m_flag;
      if (m_press[2]) begin
        c = 8'h00;
        f = 1'b0;
      end else if (m_press[0] && !m_press[1]) begin
        if (c == 8'hFF) f = 1'b1;
        c = c + 8'd1;
      end else if (m_press[1] && !m_press[0]) begin
        if (c == 8'h00) f = 1'b1;
        c = c - 8'd1;
      end
      d = m_deb;
      p = 3'b000;
      for (int b = 0; b < 3; b++) begin
        differs = 1'b1;
        for (int j = 1; j <= DEB; j++) begin
          if (hist[j][b] == m_deb[b]) differs = 1'b0;
        end
        if (differs) begin
          d[b] = ~m_deb[b];
          p[b] = d[b];
        end
      end
      for (int i = 7; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= ui_in[2:0];
      m_deb   <= d;
      m_press <= p;
      m_count <= c;
      m_flag  <= f;
`ifdef PRESS_STATUS_EN
      m_oe    <= 8'h0F;
`else
      m_oe    <= 8'h00;
`endif
    end
  end

  function automatic logic [7:0] exp_uio();
`ifdef PRESS_STATUS_EN
    return {4'h0, m_flag, m_deb};
`else
    return 8'h00;
`endif
  endfunction

  task automatic press(input logic [2:0] mask);
    @(negedge clk);
    ui_in[2:0] = mask;
    repeat (12) @(negedge clk);
    ui_in[2:0] = 3'b000;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ui_in = 8'h00;
    #3;
    total++; if (uo_out !== 8'h00) begin bad++; $display("FAIL reset_uo got=%h exp=00", uo_out); end
    total++; if (uio_out !== 8'h00) begin bad++; $display("FAIL reset_uio_out got=%h exp=00", uio_out); end
    total++; if (uio_oe !== 8'h00) begin bad++; $display("FAIL reset_uio_oe got=%h exp=00", uio_oe); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (uio_oe !== m_oe) begin bad++; $display("FAIL post_reset_oe got=%h exp=%h", uio_oe, m_oe); end
  endtask

  task automatic test_up_hold();
    for (int rep = 0; rep < 3; rep++) begin
      ui_in[0] = 1'b1;
      for (int t = 1; t <= 20; t++) begin
        @(negedge clk);
        if (t == 6) begin
          total++; if (uo_out !== 8'(rep)) begin bad++; $display("FAIL up_early t=6 got=%0d exp=%0d", uo_out, rep); end
        end
        if (t == 7) begin
          total++; if (uo_out !== 8'(rep + 1)) begin bad++; $display("FAIL up_latency t=7 got=%0d exp=%0d", uo_out, rep + 1); end
        end
        total++; if (uo_out !== m_count) begin bad++; $display("FAIL up_model got=%h exp=%h", uo_out, m_count); end
      end
      ui_in[0] = 1'b0;
      repeat (20) begin
        @(negedge clk);
        total++; if (uo_out !== m_count) begin bad++; $display("FAIL up_release got=%h exp=%h", uo_out, m_count); end
      end
    end
    total++; if (uo_out !== 8'd3) begin bad++; $display("FAIL up_total got=%0d exp=3", uo_out); end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (uo_out !== 8'h00) begin bad++; $display("FAIL async_uo got=%h exp=00", uo_out); end
    total++; if (uio_oe !== 8'h00) begin bad++; $display("FAIL async_oe got=%h exp=00", uio_oe); end
    total++; if (uio_out !== 8'h00) begin bad++; $display("FAIL async_uio got=%h exp=00", uio_out); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_glitch();
    ui_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    ui_in[0] = 1'b0;
    repeat (10) begin
      @(negedge clk);
      total++; if (uo_out !== m_count) begin bad++; $display("FAIL short_model got=%h exp=%h", uo_out, m_count); end
    end
    total++; if (uo_out !== 8'h00) begin bad++; $display("FAIL short_pulse got=%h exp=00", uo_out); end
    // Held press counted once, then 1-clock dropouts must not re-trigger.
    ui_in[0] = 1'b1;
    repeat (10) @(negedge clk);
    for (int g = 0; g < 6; g++) begin
      ui_in[0] = 1'b0;
      @(negedge clk);
      ui_in[0] = 1'b1;
      repeat (3) begin
        @(negedge clk);
        total++; if (uo_out !== m_count) begin bad++; $display("FAIL glitch_model got=%h exp=%h", uo_out, m_count); end
      end
    end
    ui_in[0] = 1'b0;
    repeat (12) @(negedge clk);
    total++; if (uo_out !== 8'h01) begin bad++; $display("FAIL glitch_hold got=%h exp=01", uo_out); end
  endtask

  task automatic test_wrap();
    press(3'b100);
    total++; if (uo_out !== 8'h00) begin bad++; $display("FAIL wrap_clear got=%h exp=00", uo_out); end
    press(3'b010);
    total++; if (uo_out !== 8'hFF) begin bad++; $display("FAIL wrap_down got=%h exp=FF", uo_out); end
    press(3'b001);
    total++; if (uo_out !== 8'h00) begin bad++; $display("FAIL wrap_up got=%h exp=00", uo_out); end
`ifdef PRESS_STATUS_EN
    total++; if (uio_out[3] !== 1'b1) begin bad++; $display("FAIL wrap_flag got=%b exp=1", uio_out[3]); end
`endif
    total++; if (uio_out !== exp_uio()) begin bad++; $display("FAIL wrap_uio got=%h exp=%h", uio_out, exp_uio()); end
  endtask

  task automatic test_both();
    press(3'b100);
    press(3'b010);
    press(3'b001);
    for (int i = 0; i < 5; i++) press(3'b001);
    total++; if (uo_out !== 8'd5) begin bad++; $display("FAIL both_setup got=%0d exp=5", uo_out); end
    press(3'b011);
    total++; if (uo_out !== 8'd5) begin bad++; $display("FAIL up_down got=%0d exp=5", uo_out); end
`ifdef PRESS_STATUS_EN
    total++; if (uio_out[3] !== 1'b1) begin bad++; $display("FAIL flag_before_clear got=%b exp=1", uio_out[3]); end
`endif
    press(3'b101);
    total++; if (uo_out !== 8'd0) begin bad++; $display("FAIL up_clear got=%0d exp=0", uo_out); end
`ifdef PRESS_STATUS_EN
    total++; if (uio_out[3] !== 1'b0) begin bad++; $display("FAIL flag_after_clear got=%b exp=0", uio_out[3]); end
`endif
  endtask

  task automatic test_reset_mid_debounce();
    press(3'b001);
    total++; if (uo_out !== 8'd1) begin bad++; $display("FAIL mid_setup got=%0d exp=1", uo_out); end
    ui_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (uo_out !== 8'd0) begin bad++; $display("FAIL mid_reset got=%0d exp=0", uo_out); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      @(negedge clk);
      if (t == 6) begin
        total++; if (uo_out !== 8'd0) begin bad++; $display("FAIL mid_early got=%0d exp=0", uo_out); end
      end
    end
    total++; if (uo_out !== 8'd1) begin bad++; $display("FAIL mid_fresh got=%0d exp=1", uo_out); end
    ui_in[0] = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_random();
    for (int s = 0; s < 200; s++) begin
      ui_in = 8'($urandom);
      repeat ($urandom_range(1, 9)) begin
        @(negedge clk);
        total++; if (uo_out !== m_count) begin bad++; $display("FAIL rnd_count seg=%0d got=%h exp=%h", s, uo_out, m_count); end
        total++; if (uio_out !== exp_uio()) begin bad++; $display("FAIL rnd_uio seg=%0d got=%h exp=%h", s, uio_out, exp_uio()); end
        total++; if (uio_oe !== m_oe) begin bad++; $display("FAIL rnd_oe seg=%0d got=%h exp=%h", s, uio_oe, m_oe); end
      end
    end
    ui_in = 8'h00;
    repeat (12) @(negedge clk);
    total++; if (uo_out !== m_count) begin bad++; $display("FAIL rnd_final got=%h exp=%h", uo_out, m_count); end
  endtask

  initial begin
    test_reset();
    test_up_hold();
    test_async_reset();
    test_glitch();
    test_wrap();
    test_both();
    test_reset_mid_debounce();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
